// File: rtl/dem_recombine_checker_pkg.sv
// Shared types and constants for the DEM element recombination checker.
// Holds the FSM encoding, default widths and the default fault threshold.
package dem_recombine_checker_pkg;

    localparam int INPUT_WIDTH       = 16;
    localparam int SUM_WIDTH         = INPUT_WIDTH + 3;
    localparam int DEM_CHK_ERR_LIMIT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2,
        FAULT = 2'd3
    } dem_chk_state_t;

endpackage

// File: rtl/dem_recombine_checker_pair_adder.sv
// Registered unsigned pair adder with carry-out growth and a valid passthrough.
// Latency 1 cycle; no backpressure, flush_i drops the in-flight valid only.
module dem_pair_adder #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         valid_o,
    output logic [W:0]   sum_o
);

    logic [W:0] sum_d;
    logic [W:0] sum_q;
    logic       valid_d;
    logic       valid_q;

    always_comb begin
        sum_d   = {1'b0, a_i} + {1'b0, b_i};
        valid_d = valid_i & ~flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign sum_o   = sum_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/dem_recombine_checker.sv
// Recombines the eight DEM element codes and checks them against the delayed DAC input.
// Latency 3 cycles from elements (SB_LATENCY+3 from x_ref_i); no backpressure.
module dem_recombine_checker #(
    parameter int INPUT_WIDTH = dem_recombine_checker_pkg::INPUT_WIDTH,
    parameter int SB_LATENCY  = 3,
    parameter int ERR_LIMIT   = dem_recombine_checker_pkg::DEM_CHK_ERR_LIMIT,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clear_i,
    input  logic                   valid_i,
    input  logic [INPUT_WIDTH-1:0] x_ref_i,
    input  logic [INPUT_WIDTH-1:0] x_el_i [8],
    output logic [INPUT_WIDTH+2:0] sum_o,
    output logic                   sum_valid_o,
    output logic                   match_o,
    output logic                   error_o,
    output logic [ERR_CNT_W-1:0]   err_count_o,
    output logic                   fault_o,
    output logic [1:0]             state_o
);

    import dem_recombine_checker_pkg::*;

    localparam int SUM_W     = INPUT_WIDTH + 3;
    localparam int REF_DEPTH = SB_LATENCY + 2;

    logic [SB_LATENCY-1:0]  vld_q;
    logic [SB_LATENCY-1:0]  vld_d;
    logic [INPUT_WIDTH-1:0] ref_q [REF_DEPTH];
    logic [INPUT_WIDTH-1:0] ref_d [REF_DEPTH];
    logic                   el_v;

    logic [INPUT_WIDTH:0]   s1_sum [4];
    logic [3:0]             s1_v;
    logic [INPUT_WIDTH+1:0] s2_sum [2];
    logic [1:0]             s2_v;

    logic [SUM_W-1:0]       s3_pre;
    logic [SUM_W-1:0]       ref_ext;
    logic                   cmp_en;
    logic                   cmp_eq;
    logic                   mismatch;
    logic                   go_fault;

    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [ERR_CNT_W-1:0]   err_cnt_d;
    logic [ERR_CNT_W-1:0]   cnt_inc;
    logic                   error_q;
    logic                   error_d;
    logic                   match_q;
    logic                   match_d;

    dem_chk_state_t         state_q;
    dem_chk_state_t         state_d;

    always_comb begin
        vld_d[0] = valid_i;
        for (int i = 1; i < SB_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        if (clear_i) begin
            vld_d = '0;
        end
        ref_d[0] = x_ref_i;
        for (int i = 1; i < REF_DEPTH; i++) begin
            ref_d[i] = ref_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q <= '0;
            for (int i = 0; i < REF_DEPTH; i++) begin
                ref_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            ref_q <= ref_d;
        end
    end

    assign el_v = vld_q[SB_LATENCY-1];

    for (genvar k = 0; k < 4; k++) begin : g_stage1
        dem_pair_adder #(.W(INPUT_WIDTH)) u_add (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .flush_i (clear_i),
            .valid_i (el_v),
            .a_i     (x_el_i[2*k]),
            .b_i     (x_el_i[2*k+1]),
            .valid_o (s1_v[k]),
            .sum_o   (s1_sum[k])
        );
    end

    for (genvar k = 0; k < 2; k++) begin : g_stage2
        dem_pair_adder #(.W(INPUT_WIDTH+1)) u_add (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .flush_i (clear_i),
            .valid_i (s1_v[2*k] & s1_v[2*k+1]),
            .a_i     (s1_sum[2*k]),
            .b_i     (s1_sum[2*k+1]),
            .valid_o (s2_v[k]),
            .sum_o   (s2_sum[k])
        );
    end

    dem_pair_adder #(.W(INPUT_WIDTH+2)) u_stage3 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (clear_i),
        .valid_i (cmp_en),
        .a_i     (s2_sum[0]),
        .b_i     (s2_sum[1]),
        .valid_o (sum_valid_o),
        .sum_o   (sum_o)
    );

    // Compare on the stage-3 input so the verdict registers on the same edge as sum_o.
    always_comb begin
        cmp_en   = &s2_v;
        s3_pre   = {1'b0, s2_sum[0]} + {1'b0, s2_sum[1]};
        ref_ext  = {3'b000, ref_q[REF_DEPTH-1]};
        cmp_eq   = (s3_pre == ref_ext);
        mismatch = cmp_en & ~cmp_eq;
        cnt_inc  = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
        go_fault = mismatch && (cnt_inc >= ERR_CNT_W'(ERR_LIMIT));
    end

    always_comb begin
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        match_d   = 1'b0;
        if (clear_i) begin
            error_d   = 1'b0;
            err_cnt_d = '0;
        end else if (cmp_en) begin
            match_d = cmp_eq;
            if (!cmp_eq) begin
                error_d   = 1'b1;
                err_cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_q   <= 1'b0;
            err_cnt_q <= '0;
            match_q   <= 1'b0;
        end else begin
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
            match_q   <= match_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (valid_i) state_d = PRIME;
                PRIME:   if (cmp_en) state_d = go_fault ? FAULT : CHECK;
                CHECK:   if (go_fault) state_d = FAULT;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        state_o = state_q;
        fault_o = (state_q == FAULT);
    end

    assign match_o     = match_q;
    assign error_o     = error_q;
    assign err_count_o = err_cnt_q;

endmodule
